// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg
// Shared types for the memory-side blocks of the CPU.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM handshake state (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : mem_arbiter grant state (IDLE, DGRANT, IGRANT)
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_streak.sv
// ============================================================================
// mem_arb_streak
// Saturating counter of consecutive dcache words completed while the icache
// is waiting. Clear has priority over increment.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   inc       : count one completed dcache word
//   clr       : clear the streak
//   count     : current streak value
//   sat       : count has reached MAX
// ============================================================================
module mem_arb_streak #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = (count >= W'(MAX));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block evaluation order.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !sat)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// Arbitrates the single-port RAM between the icache word fetch and the dcache
// read/write traffic. A dcache two-word block (first word daddr[2]==0) holds
// the bus for both words; otherwise the dcache wins ties unless the icache has
// watched MAX_DSTREAK dcache words go by, in which case it gets one grant.
//
// Optional feature: define MEM_ARB_STATS_EN to add icount/dcount, per-requester
// completed-word counters (cleared by reset, wrap at 2^32).
//
// Ports:
//   CLK, nRST                  : clock, asynchronous active-low reset
//   iREN, iaddr                : icache read request / word address
//   iwait, iload               : icache wait (low on completion) / read data
//   dREN, dWEN, daddr, dstore  : dcache read, write, word address, write data
//   dwait, dload               : dcache wait (low on completion) / read data
//   ramREN, ramWEN             : RAM read / write enable
//   ramaddr, ramstore          : RAM address / write data
//   ramload, ramstate          : RAM read data / handshake state
//   icount, dcount             : completed-word counters (MEM_ARB_STATS_EN)
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4,
    parameter int STREAK_W    = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
   ,output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    arb_state_t          state, next_state;
    logic                second_word, next_second_word;
    logic [STREAK_W-1:0] streak;
    logic                streak_sat;

    ramstate_t rs;
    logic      dreq, acc, d_done, i_done, istarve;

    assign rs      = ramstate_t'(ramstate);
    assign dreq    = dREN | dWEN;
    assign acc     = (rs == ACCESS);
    assign d_done  = (state == DGRANT) && dreq && acc;
    assign i_done  = (state == IGRANT) && iREN && acc;
    assign istarve = iREN && (streak >= STREAK_W'(MAX_DSTREAK));

    // The streak only means something while the icache is waiting, so any
    // cycle without iREN (or an icache completion) resets it.
    mem_arb_streak #(
        .MAX (MAX_DSTREAK),
        .W   (STREAK_W)
    ) u_streak (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (d_done && !streak_sat),
        .clr   (!iREN || i_done),
        .count (streak),
        .sat   (streak_sat)
    );

    // ------------------------------------------------------------------
    // Next-state logic. second_word marks the locked second half of a
    // two-word block so a run of even-word addresses is not one endless
    // burst; the starvation check happens in IDLE once the burst is over.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        next_state       = state;
        next_second_word = 1'b0;
        unique case (state)
            IDLE: begin
                if (dreq && !istarve)
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end
            DGRANT: begin
                if (!dreq) begin
                    next_state = IDLE;
                end else if (acc) begin
                    if (!daddr[2] && !second_word) begin
                        next_state       = DGRANT;
                        next_second_word = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_second_word = second_word;
                end
            end
            IGRANT: begin
                if (!iREN || acc)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            second_word <= 1'b0;
        end else begin
            state       <= next_state;
            second_word <= next_second_word;
        end
    end

    // ------------------------------------------------------------------
    // Output mux: purely a function of the registered grant and the
    // current request/RAM inputs, so reset forces the idle values at once.
    // ------------------------------------------------------------------
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        unique case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;   // write wins when both asserted
                if (d_done) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (i_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (i_done) icount <= icount + 32'd1;
            if (d_done) dcount <= dcount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
// Honours MEM_ARB_STATS_EN when defined for the build.
// ============================================================================
module tb_mem_arbiter;

    localparam int MAXS = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] icount, dcount;
`endif

    mem_arbiter #(.MAX_DSTREAK(MAXS), .STREAK_W(3)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARB_STATS_EN
       ,.icount   (icount),
        .dcount   (dcount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the bus, how many words of the current
    // dcache grant have completed, and how many dcache words the waiting
    // icache has seen. Counts instead of encoded states.
    // ------------------------------------------------------------------
    int          owner;        // 0 none, 1 dcache, 2 icache
    int          dwords;       // completed words in the current dcache grant
    int          wait_count;   // dcache words completed while icache waits
    logic [31:0] m_icount, m_dcount;

    task automatic model_reset();
        owner      = 0;
        dwords     = 0;
        wait_count = 0;
        m_icount   = 0;
        m_dcount   = 0;
    endtask

    // Compare outputs for the current inputs, then advance the model and
    // move to just after the next rising edge.
    task automatic tick();
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        logic        dq, ac;
        @(negedge CLK);
        dq = dREN | dWEN;
        ac = (ramstate == 2'd2);
        e_iwait = 1; e_dwait = 1; e_ren = 0; e_wen = 0;
        e_iload = 0; e_dload = 0; e_addr = 0; e_store = 0;
        if (owner == 1) begin
            e_addr = daddr; e_store = dstore;
            e_wen  = dWEN;  e_ren   = dREN & ~dWEN;
            if (dq && ac) begin e_dwait = 0; e_dload = ramload; end
        end else if (owner == 2) begin
            e_addr = iaddr; e_ren = iREN;
            if (iREN && ac) begin e_iwait = 0; e_iload = ramload; end
        end
        check("iwait", iwait, e_iwait);
        check("dwait", dwait, e_dwait);
        check("iload", iload, e_iload);
        check("dload", dload, e_dload);
        check("ramREN", ramREN, e_ren);
        check("ramWEN", ramWEN, e_wen);
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
`ifdef MEM_ARB_STATS_EN
        check("icount", icount, m_icount);
        check("dcount", dcount, m_dcount);
`endif
        // advance
        case (owner)
            0: begin
                dwords = 0;
                if (dq && !(iREN && wait_count >= MAXS)) owner = 1;
                else if (iREN) owner = 2;
            end
            1: begin
                if (!dq) owner = 0;
                else if (ac) begin
                    m_dcount++;
                    if (wait_count < MAXS) wait_count++;
                    dwords++;
                    // a block starting on an even word keeps the bus for one more word
                    if (!(dwords == 1 && daddr[2] == 1'b0)) owner = 0;
                end
            end
            default: begin
                if (!iREN) owner = 0;
                else if (ac) begin
                    m_icount++;
                    wait_count = 0;
                    owner = 0;
                end
            end
        endcase
        if (!iREN) wait_count = 0;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    endtask

    initial begin
        idle_inputs();
        nRST = 0;
        model_reset();
        #12;
        // reset state
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ramREN", ramREN, 0);
        check("rst_ramaddr", ramaddr, 0);
        @(posedge CLK); #1;
        nRST = 1;

        // --- icache fetch, latency BUSY,BUSY,ACCESS ---
        iREN = 1; iaddr = 32'h40;
        #1 check("i_idle_ren", ramREN, 0);
        tick();                                   // IDLE
        ramstate = 2'd1;
        #1 check("i_grant_ren", ramREN, 1);
        check("i_grant_addr", ramaddr, 32'h40);
        tick();
        tick();
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        #1 check("i_iwait", iwait, 0);
        check("i_iload", iload, 32'hDEADBEEF);
        tick();
        ramstate = 2'd0; iREN = 0;
        #1 check("i_back_idle", ramREN, 0);
        tick();

        // --- dcache two-word fetch with icache waiting ---
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
        tick();                                   // IDLE, dcache wins
        ramstate = 2'd2; ramload = 32'h11;
        #1 check("b0_dwait", dwait, 0);
        check("b0_dload", dload, 32'h11);
        check("b0_iwait", iwait, 1);
        tick();
        daddr = 32'h104; ramload = 32'h22;
        #1 check("b1_addr", ramaddr, 32'h104);
        check("b1_dwait", dwait, 0);
        check("b1_iwait", iwait, 1);
        tick();
        dREN = 0; ramstate = 2'd0;
        tick();                                   // IDLE
        ramstate = 2'd2; ramload = 32'h33;
        #1 check("b_igrant", iwait, 0);
        tick();
        iREN = 0; ramstate = 2'd0;
        tick();

        // --- four writes while icache waits; fifth waits for icache ---
        iREN = 1; iaddr = 32'hC0; dWEN = 1;
        for (int k = 0; k < 2; k++) begin
            daddr = 32'h200 + k * 16; ramstate = 2'd0;
            tick();                               // IDLE
            ramstate = 2'd2;
            tick();                               // even word
            daddr = daddr + 8;
            tick();                               // second word
        end
        daddr = 32'h220; ramstate = 2'd0;
        tick();                                   // IDLE, icache starved
        ramstate = 2'd2; ramload = 32'h44;
        #1 check("s_igrant_addr", ramaddr, 32'hC0);
        check("s_iwait", iwait, 0);
        check("s_dwait", dwait, 1);
        check("s_no_wen", ramWEN, 0);
        tick();
        iREN = 0; ramstate = 2'd0;
        tick();                                   // IDLE
        #1 check("s_fifth_wen", ramWEN, 1);
        check("s_fifth_addr", ramaddr, 32'h220);
        tick();
        dWEN = 0;
        tick();

        // --- read+write together, then abort while BUSY ---
        dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h12345678;
        tick();
        ramstate = 2'd1;
        #1 check("rw_wen", ramWEN, 1);
        check("rw_ren", ramREN, 0);
        check("rw_store", ramstore, 32'h12345678);
        tick();
        dREN = 0; dWEN = 0;
        #1 check("ab_ren", ramREN, 0);
        check("ab_wen", ramWEN, 0);
        tick();
        #1 check("ab_idle_addr", ramaddr, 0);
        tick();

        // --- async reset mid-DGRANT ---
        dREN = 1; daddr = 32'h400; ramstate = 2'd1;
        tick();
        #1 check("pre_rst_ren", ramREN, 1);
        #2 nRST = 0;
        #1 check("arst_ren", ramREN, 0);
        check("arst_wen", ramWEN, 0);
        check("arst_iwait", iwait, 1);
        check("arst_dwait", dwait, 1);
        check("arst_addr", ramaddr, 0);
`ifdef MEM_ARB_STATS_EN
        check("arst_icount", icount, 0);
        check("arst_dcount", dcount, 0);
`endif
        model_reset();
        @(posedge CLK); #1;
        nRST = 1;
        idle_inputs();
        tick();

        // --- random traffic ---
        for (int c = 0; c < 3000; c++) begin
            iREN     = ($urandom_range(0, 9) < 7);
            dREN     = ($urandom_range(0, 9) < 4);
            dWEN     = ($urandom_range(0, 9) < 3);
            iaddr    = $urandom & 32'h0000_0FFC;
            daddr    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
